// File: rtl/alien_pkg.sv
// Shared constants and types for the alien fire scheduling logic.
package alien_pkg;

   localparam int ROWS          = 4;
   localparam int COLS          = 8;
   localparam int ALIEN_W       = 32;
   localparam int ALIEN_H       = 32;
   localparam int SHOT_X_OFFSET = 15;
   localparam int SHOT_Y_OFFSET = 32;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE,
      PICK,
      SCAN,
      ISSUE
   } fire_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; advances one step per enabled clock, holds otherwise.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        enable,
   output logic [15:0] lfsr_value
);
   import alien_pkg::*;

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (enable) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) lfsr_q <= SEED;
      else         lfsr_q <= lfsr_d;
   end

   assign lfsr_value = lfsr_q;

endmodule

// File: rtl/alien_fire_scheduler.sv
// Chooses when and which alien fires: random column, bottom-most live alien,
// gated by a frame cooldown and shot-slot availability.
module alien_fire_scheduler #(
   parameter int          ROWS            = alien_pkg::ROWS,
   parameter int          COLS            = alien_pkg::COLS,
   parameter int          ALIEN_W         = alien_pkg::ALIEN_W,
   parameter int          ALIEN_H         = alien_pkg::ALIEN_H,
   parameter int          SHOT_X_OFFSET   = alien_pkg::SHOT_X_OFFSET,
   parameter int          SHOT_Y_OFFSET   = alien_pkg::SHOT_Y_OFFSET,
   parameter int          COOLDOWN_FRAMES = 45,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     startOfFrame,
   input  logic                     playGame,
   input  logic [ROWS*COLS-1:0]     aliensAlive,
   input  logic signed [10:0]       gridTopLeftX,
   input  logic signed [10:0]       gridTopLeftY,
   input  logic                     shotSlotFree,
   output logic                     fireReq,
   output logic signed [10:0]       shooterX,
   output logic signed [10:0]       shooterY,
   output logic [$clog2(COLS)-1:0]  shooterCol,
   output logic                     busy
);
   import alien_pkg::*;

   localparam int CB  = $clog2(COLS);
   localparam int RB  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CDW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

   localparam logic [RB-1:0]  ROW_LAST   = RB'(ROWS - 1);
   localparam logic [CB:0]    TRIED_LAST = (CB + 1)'(COLS - 1);
   localparam logic [CDW-1:0] CD_RELOAD  = CDW'(COOLDOWN_FRAMES);

   fire_state_t              state_q, state_d;
   logic [CB-1:0]            col_q, col_d;
   logic [RB-1:0]            row_q, row_d;
   logic [CB:0]              tried_q, tried_d;
   logic [ROWS*COLS-1:0]     snap_q, snap_d;
   logic [CDW-1:0]           cooldown_q, cooldown_d;
   logic                     fire_req_q, fire_req_d;
   logic [10:0]              shooter_x_q, shooter_x_d;
   logic [10:0]              shooter_y_q, shooter_y_d;
   logic [CB-1:0]            shooter_col_q, shooter_col_d;

   logic [15:0] lfsr_value;
   logic        unused_lfsr_bits;
   logic        reload;
   logic        hit;
   logic [11:0] x_sum, y_sum;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk        (clk),
      .resetN     (resetN),
      .enable     (playGame),
      .lfsr_value (lfsr_value)
   );

   assign unused_lfsr_bits = ^lfsr_value[15:CB];

   // COLS is a power of two, so {row,col} equals row*COLS+col
   assign hit   = snap_q[{row_q, col_q}];
   assign x_sum = {gridTopLeftX[10], gridTopLeftX} + 12'(col_q) * 12'(ALIEN_W) + 12'(SHOT_X_OFFSET);
   assign y_sum = {gridTopLeftY[10], gridTopLeftY} + 12'(row_q) * 12'(ALIEN_H) + 12'(SHOT_Y_OFFSET);

   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      row_d         = row_q;
      tried_d       = tried_q;
      snap_d        = snap_q;
      fire_req_d    = 1'b0;
      shooter_x_d   = shooter_x_q;
      shooter_y_d   = shooter_y_q;
      shooter_col_d = shooter_col_q;
      reload        = 1'b0;

      case (state_q)
         IDLE: begin
            if (cooldown_q == '0 && shotSlotFree) state_d = PICK;
         end
         PICK: begin
            col_d   = lfsr_value[CB-1:0];
            row_d   = ROW_LAST;
            tried_d = '0;
            snap_d  = aliensAlive;
            state_d = SCAN;
         end
         SCAN: begin
            if (hit) begin
               state_d       = ISSUE;
               shooter_x_d   = x_sum[10:0];
               shooter_y_d   = y_sum[10:0];
               shooter_col_d = col_q;
            end else if (row_q != '0) begin
               row_d = row_q - RB'(1);
            end else begin
               col_d   = col_q + CB'(1);
               row_d   = ROW_LAST;
               tried_d = tried_q + (CB + 1)'(1);
               if (tried_q == TRIED_LAST) begin
                  state_d = IDLE;
                  reload  = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (shotSlotFree) begin
               fire_req_d = 1'b1;
               reload     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (reload)                               cooldown_d = CD_RELOAD;
      else if (startOfFrame && cooldown_q != '0) cooldown_d = cooldown_q - CDW'(1);
      else                                      cooldown_d = cooldown_q;

      // Leaving the game aborts any pick but keeps the last muzzle position visible
      if (!playGame) begin
         state_d       = IDLE;
         fire_req_d    = 1'b0;
         cooldown_d    = CD_RELOAD;
         shooter_x_d   = shooter_x_q;
         shooter_y_d   = shooter_y_q;
         shooter_col_d = shooter_col_q;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q       <= IDLE;
         col_q         <= '0;
         row_q         <= '0;
         tried_q       <= '0;
         snap_q        <= '0;
         cooldown_q    <= CD_RELOAD;
         fire_req_q    <= 1'b0;
         shooter_x_q   <= '0;
         shooter_y_q   <= '0;
         shooter_col_q <= '0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         tried_q       <= tried_d;
         snap_q        <= snap_d;
         cooldown_q    <= cooldown_d;
         fire_req_q    <= fire_req_d;
         shooter_x_q   <= shooter_x_d;
         shooter_y_q   <= shooter_y_d;
         shooter_col_q <= shooter_col_d;
      end
   end

   assign fireReq    = fire_req_q;
   assign shooterX   = shooter_x_q;
   assign shooterY   = shooter_y_q;
   assign shooterCol = shooter_col_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Directed bench for alien_fire_scheduler with a reference LFSR for column prediction.
module tb_alien_fire_scheduler;

   logic               clk = 1'b0;
   logic               resetN;
   logic               startOfFrame;
   logic               playGame;
   logic [31:0]        aliensAlive;
   logic signed [10:0] gridTopLeftX;
   logic signed [10:0] gridTopLeftY;
   logic               shotSlotFree;
   logic               fireReq;
   logic signed [10:0] shooterX;
   logic signed [10:0] shooterY;
   logic [2:0]         shooterCol;
   logic               busy;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] mdl;
   logic [2:0]  exp_col;
   logic        busy_prev = 1'b0;
   int          n_busy, n_fire, pick_t, fire_t;
   logic [10:0] exp_x, exp_y;

   always #5 clk = ~clk;

   alien_fire_scheduler #(.COOLDOWN_FRAMES(2)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .playGame     (playGame),
      .aliensAlive  (aliensAlive),
      .gridTopLeftX (gridTopLeftX),
      .gridTopLeftY (gridTopLeftY),
      .shotSlotFree (shotSlotFree),
      .fireReq      (fireReq),
      .shooterX     (shooterX),
      .shooterY     (shooterY),
      .shooterCol   (shooterCol),
      .busy         (busy)
   );

   // Reference LFSR: x^16+x^14+x^13+x^11, shifting while the game runs
   always @(posedge clk or negedge resetN) begin
      if (!resetN)       mdl <= 16'hACE1;
      else if (playGame) mdl <= {mdl[14:0], mdl[15] ^ mdl[13] ^ mdl[12] ^ mdl[10]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (busy && !busy_prev) exp_col = mdl[2:0];
      busy_prev = busy;
   endtask

   task automatic run(input int n);
      n_busy = 0;
      n_fire = 0;
      repeat (n) begin
         tick();
         if (busy)    n_busy++;
         if (fireReq) n_fire++;
      end
   endtask

   task automatic sof2();
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
   endtask

   task automatic wait_fire(input int max);
      pick_t = -1;
      fire_t = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (busy && pick_t < 0) pick_t = i;
         if (fireReq) begin
            fire_t = i;
            break;
         end
      end
   endtask

   task automatic chk_pos(input string tag, input logic [10:0] ex, input logic [10:0] ey,
                          input logic [2:0] ec);
      chk({tag, "_x"},   {21'b0, shooterX},   {21'b0, ex});
      chk({tag, "_y"},   {21'b0, shooterY},   {21'b0, ey});
      chk({tag, "_col"}, {29'b0, shooterCol}, {29'b0, ec});
   endtask

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; playGame = 1'b0; aliensAlive = '1;
      gridTopLeftX = 11'sd100; gridTopLeftY = 11'sd40; shotSlotFree = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_fire", {31'b0, fireReq}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk_pos("rst", 11'd0, 11'd0, 3'd0);

      // Cooldown expiry with everyone alive: bottom row of random column
      resetN = 1'b1; playGame = 1'b1;
      tick();
      chk("cd_hold_busy", {31'b0, busy}, 0);
      sof2();
      wait_fire(10);
      chk("pick_delay", pick_t, 1);
      chk("fire_latency", fire_t - pick_t, 3);
      chk_pos("bottom", 11'(115 + 32 * int'(exp_col)), 11'd168, exp_col);
      tick();
      chk("fire_one_cycle", {31'b0, fireReq}, 0);

      // Single survivor at row 1, col 5
      aliensAlive = 32'h0000_2000;
      for (int s = 0; s < 20; s++) begin
         if (s < 10) begin
            gridTopLeftX = 11'sd100;  gridTopLeftY = 11'sd40;  exp_x = 11'd275; exp_y = 11'd104;
         end else if (s < 18) begin
            gridTopLeftX = -11'sd30;  gridTopLeftY = -11'sd10; exp_x = 11'd145; exp_y = 11'd54;
         end else begin
            gridTopLeftX = 11'sd1000; gridTopLeftY = 11'sd40;  exp_x = 11'h497; exp_y = 11'd104;
         end
         sof2();
         wait_fire(50);
         chk("surv_fired", {31'b0, fire_t > 0}, 1);
         chk_pos("surv", exp_x, exp_y, 3'd5);
      end

      // No survivors: full sweep then back to idle with cooldown reloaded
      aliensAlive = '0;
      sof2();
      run(60);
      chk("empty_busy_cycles", n_busy, 33);
      chk("empty_no_fire", n_fire, 0);
      run(10);
      chk("empty_cd_reloaded", n_busy, 0);
      chk_pos("empty_hold", 11'h497, 11'd104, 3'd5);

      // Slot handshake: no start while slot busy, then hold in ISSUE
      aliensAlive = '1; gridTopLeftX = 11'sd100; gridTopLeftY = 11'sd40; shotSlotFree = 1'b0;
      sof2();
      run(10);
      chk("slot_wait_busy", n_busy, 0);
      chk("slot_wait_fire", n_fire, 0);
      chk_pos("slot_wait_hold", 11'h497, 11'd104, 3'd5);
      shotSlotFree = 1'b1;
      tick();
      shotSlotFree = 1'b0;
      run(10);
      chk("issue_hold_fire", n_fire, 0);
      chk("issue_hold_busy", {31'b0, busy}, 1);
      exp_x = 11'(115 + 32 * int'(exp_col));
      chk_pos("issue_latched", exp_x, 11'd168, exp_col);
      gridTopLeftX = 11'sd0; gridTopLeftY = 11'sd0;
      run(3);
      chk_pos("issue_grid_ignored", exp_x, 11'd168, exp_col);
      shotSlotFree = 1'b1;
      run(10);
      chk("slot_release_fire", n_fire, 1);
      chk_pos("post_fire_hold", exp_x, 11'd168, exp_col);

      // Snapshot: kill everyone after PICK, shot still issues
      gridTopLeftX = 11'sd100; gridTopLeftY = 11'sd40;
      sof2();
      for (int i = 0; i < 5 && !busy; i++) tick();
      chk("snap_pick", {31'b0, busy}, 1);
      tick();
      aliensAlive = '0;
      wait_fire(10);
      chk("snap_fired", {31'b0, fire_t > 0}, 1);
      chk_pos("snap", 11'(115 + 32 * int'(exp_col)), 11'd168, exp_col);

      // playGame drop while waiting in ISSUE
      aliensAlive = '1;
      sof2();
      shotSlotFree = 1'b1;
      tick();
      shotSlotFree = 1'b0;
      run(5);
      chk("pg_in_issue", {31'b0, busy}, 1);
      playGame = 1'b0;
      tick();
      chk("pg_drop_fire", {31'b0, fireReq}, 0);
      chk("pg_drop_busy", {31'b0, busy}, 0);
      playGame = 1'b1; shotSlotFree = 1'b1;
      run(10);
      chk("pg_cd_reload_busy", n_busy, 0);
      chk("pg_cd_reload_fire", n_fire, 0);

      // Asynchronous reset in the middle of a long scan
      aliensAlive = '0;
      sof2();
      for (int i = 0; i < 5 && !busy; i++) tick();
      chk("rst_scan_started", {31'b0, busy}, 1);
      run(3);
      resetN = 1'b0;
      #2;
      chk("midrst_fire", {31'b0, fireReq}, 0);
      chk("midrst_busy", {31'b0, busy}, 0);
      chk_pos("midrst", 11'd0, 11'd0, 3'd0);
      busy_prev = 1'b0;
      repeat (2) @(posedge clk);
      resetN = 1'b1;
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule
